// File: rtl/stw_bist_controller.sv
// STW self-test sequencer: applies a fixed multiply-add vector table to the
// systolic array and folds per-PE mismatches into a sticky fault map.
module stw_bist_controller #(
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int WORD_SIZE   = 16,
    parameter int NUM_VECTORS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   bist_start,
    output logic                   bist_busy,
    output logic                   bist_done,
    output logic                   bist_pass,
    output logic                   bist_timeout,
    output logic [ROWS*COLS-1:0]   fault_map,
    output logic [WORD_SIZE-1:0]   stw_mult_op1,
    output logic [WORD_SIZE-1:0]   stw_mult_op2,
    output logic [WORD_SIZE-1:0]   stw_add_op,
    output logic [WORD_SIZE-1:0]   stw_expected,
    output logic                   stw_test_load_en,
    output logic                   stw_start,
    input  logic                   stw_complete_in,
    input  logic [ROWS*COLS-1:0]   stw_result_mat_in
);

    localparam int W  = WORD_SIZE;
    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [1:0] LAST = 2'(NUM_VECTORS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_WAIT, S_CAPTURE, S_DONE
    } state_t;

    state_t          state_q;
    logic [1:0]      vec_idx_q;
    logic [CW-1:0]   cnt_q;
    logic [1:0]      nidx;
    logic [W-1:0]    alt;
    logic [W-1:0]    op1_d, op2_d, add_d, exp_d;
    logic [N-1:0]    fault_q;
    logic            busy_q, done_q, pass_q, tout_q, load_q, start_q;
    logic [W-1:0]    op1_q, op2_q, add_q, exp_q;

    // Operands of the vector that the next LOAD will apply.
    always_comb begin
        alt = '0;
        for (int i = 0; i < W; i++) alt[i] = (i % 2 == 0);
        nidx  = (state_q == S_IDLE) ? 2'd0 : vec_idx_q + 2'd1;
        op1_d = '0;
        op2_d = '0;
        add_d = '0;
        case (nidx)
            2'd0: begin op1_d = W'(3); op2_d = W'(5); add_d = W'(7); end
            2'd1: begin op1_d = '1;    op2_d = W'(1); add_d = W'(1); end
            2'd2: begin op1_d = alt;   op2_d = W'(2); add_d = '0;    end
            default: ;
        endcase
        exp_d = op1_d * op2_d + add_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            vec_idx_q <= '0;
            cnt_q     <= '0;
            fault_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            tout_q    <= 1'b0;
            load_q    <= 1'b0;
            start_q   <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
            add_q     <= '0;
            exp_q     <= '0;
        end else begin
            load_q  <= 1'b0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                S_IDLE: if (bist_start) begin
                    state_q   <= S_LOAD;
                    busy_q    <= 1'b1;
                    load_q    <= 1'b1;
                    fault_q   <= '0;
                    pass_q    <= 1'b0;
                    tout_q    <= 1'b0;
                    vec_idx_q <= '0;
                    op1_q     <= op1_d;
                    op2_q     <= op2_d;
                    add_q     <= add_d;
                    exp_q     <= exp_d;
                end
                S_LOAD: begin
                    state_q <= S_START;
                    start_q <= 1'b1;
                end
                S_START: begin
                    state_q <= S_WAIT;
                    cnt_q   <= '0;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    // cnt_q == 0 is the guard cycle: complete is stale there.
                    if (cnt_q != '0 && stw_complete_in) begin
                        state_q <= S_CAPTURE;
                    end else if (cnt_q == CW'(TIMEOUT)) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        tout_q  <= 1'b1;
                        pass_q  <= 1'b0;
                        fault_q <= '1;
                    end
                end
                S_CAPTURE: begin
                    fault_q <= fault_q | stw_result_mat_in;
                    if (vec_idx_q == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        pass_q  <= ~|(fault_q | stw_result_mat_in);
                    end else begin
                        state_q   <= S_LOAD;
                        load_q    <= 1'b1;
                        vec_idx_q <= vec_idx_q + 2'd1;
                        op1_q     <= op1_d;
                        op2_q     <= op2_d;
                        add_q     <= add_d;
                        exp_q     <= exp_d;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bist_busy        = busy_q;
    assign bist_done        = done_q;
    assign bist_pass        = pass_q;
    assign bist_timeout     = tout_q;
    assign fault_map        = fault_q;
    assign stw_mult_op1     = op1_q;
    assign stw_mult_op2     = op2_q;
    assign stw_add_op       = add_q;
    assign stw_expected     = exp_q;
    assign stw_test_load_en = load_q;
    assign stw_start        = start_q;

endmodule

// File: tb/tb_stw_bist_controller.sv
// Directed bench for stw_bist_controller: scenario table plus reset sequences,
// with a small array responder driving complete/result.
module tb_stw_bist_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        bist_start;
    logic        bist_busy, bist_done, bist_pass, bist_timeout;
    logic [15:0] fault_map;
    logic [15:0] stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected;
    logic        stw_test_load_en, stw_start;
    logic        stw_complete_in;
    logic [15:0] stw_result_mat_in;

    stw_bist_controller #(
        .ROWS(4), .COLS(4), .WORD_SIZE(16), .NUM_VECTORS(4), .TIMEOUT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bist_start(bist_start),
        .bist_busy(bist_busy),
        .bist_done(bist_done),
        .bist_pass(bist_pass),
        .bist_timeout(bist_timeout),
        .fault_map(fault_map),
        .stw_mult_op1(stw_mult_op1),
        .stw_mult_op2(stw_mult_op2),
        .stw_add_op(stw_add_op),
        .stw_expected(stw_expected),
        .stw_test_load_en(stw_test_load_en),
        .stw_start(stw_start),
        .stw_complete_in(stw_complete_in),
        .stw_result_mat_in(stw_result_mat_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] op1, op2, add, exp;
    } vec_t;

    typedef struct {
        string       name;
        bit          auto_c;
        bit          inject;
        bit          stuck;
        int          restart;
        int          done_cyc;
        bit          pass;
        bit          tout;
        logic [15:0] fmap;
        int          nvec;
    } case_t;

    vec_t  vt[4];
    case_t cases[5];

    int nchecks = 0;
    int nerr    = 0;
    int cyc;
    bit p1, p2, auto_c, inject, stuck;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock; array model answers complete two cycles after stw_start.
    task automatic step();
        logic s0;
        s0 = stw_start;
        @(posedge clk);
        #1;
        p2 = p1;
        p1 = s0;
        stw_complete_in   = stuck | (auto_c & p2);
        stw_result_mat_in = (inject && stw_mult_op2 == 16'd2) ? 16'h0020 : 16'h0;
    endtask

    task automatic run_case(input case_t c);
        int  nload, nstart, extra;
        bit  got;
        p1 = 0; p2 = 0;
        auto_c = c.auto_c; inject = c.inject; stuck = c.stuck;
        stw_complete_in = stuck;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        cyc = 1; nload = 0; nstart = 0; got = 0;
        chk({c.name, "_busy"}, 32'(bist_busy), 32'd1);
        for (int k = 0; k < 100 && !got; k++) begin
            if (stw_test_load_en) begin
                if (nload < 4) begin
                    chk({c.name, "_op1"}, 32'(stw_mult_op1), 32'(vt[nload].op1));
                    chk({c.name, "_op2"}, 32'(stw_mult_op2), 32'(vt[nload].op2));
                    chk({c.name, "_add"}, 32'(stw_add_op), 32'(vt[nload].add));
                    chk({c.name, "_exp"}, 32'(stw_expected), 32'(vt[nload].exp));
                end
                nload++;
            end
            if (stw_start) nstart++;
            if (bist_done) begin
                got = 1;
                chk({c.name, "_done_cyc"}, 32'(cyc), 32'(c.done_cyc));
                chk({c.name, "_timeout"}, 32'(bist_timeout), 32'(c.tout));
                chk({c.name, "_fmap"}, 32'(fault_map), 32'(c.fmap));
            end else begin
                bist_start = (cyc == c.restart);
                step();
                bist_start = 1'b0;
                cyc++;
            end
        end
        if (!got) chk({c.name, "_done_seen"}, 32'd0, 32'd1);
        chk({c.name, "_nload"}, 32'(nload), 32'(c.nvec));
        chk({c.name, "_nstart"}, 32'(nstart), 32'(c.nvec));
        step();
        chk({c.name, "_pass"}, 32'(bist_pass), 32'(c.pass));
        chk({c.name, "_idle_busy"}, 32'(bist_busy), 32'd0);
        extra = 0;
        for (int k = 0; k < 5; k++) begin
            extra += int'(bist_done) + int'(bist_busy) + int'(stw_test_load_en);
            step();
        end
        chk({c.name, "_quiet_after"}, 32'(extra), 32'd0);
        chk({c.name, "_timeout_held"}, 32'(bist_timeout), 32'(c.tout));
        chk({c.name, "_fmap_held"}, 32'(fault_map), 32'(c.fmap));
    endtask

    initial begin
        vt[0] = '{16'd3,    16'd5, 16'd7, 16'd22};
        vt[1] = '{16'hFFFF, 16'd1, 16'd1, 16'h0000};
        vt[2] = '{16'h5555, 16'd2, 16'd0, 16'hAAAA};
        vt[3] = '{16'h0000, 16'd0, 16'd0, 16'h0000};
        //          name      auto inj stk rst done pass to  fmap      nvec
        cases[0] = '{"clean",   1, 0, 0, 0, 21, 1, 0, 16'h0000, 4};
        cases[1] = '{"pe5",     1, 1, 0, 0, 21, 0, 0, 16'h0020, 4};
        cases[2] = '{"stuck",   0, 0, 1, 0, 21, 1, 0, 16'h0000, 4};
        cases[3] = '{"busystart", 1, 0, 0, 8, 21, 1, 0, 16'h0000, 4};
        cases[4] = '{"tmo",     0, 0, 0, 0, 12, 0, 1, 16'hFFFF, 1};

        rst = 1'b0;
        bist_start = 1'b0;
        stw_complete_in = 1'b0;
        stw_result_mat_in = '0;
        auto_c = 0; inject = 0; stuck = 0; p1 = 0; p2 = 0;
        #3;
        chk("rst_busy", 32'(bist_busy), 32'd0);
        chk("rst_done", 32'(bist_done), 32'd0);
        chk("rst_pass", 32'(bist_pass), 32'd0);
        chk("rst_fmap", 32'(fault_map), 32'd0);
        chk("rst_op1", 32'(stw_mult_op1), 32'd0);
        chk("rst_exp", 32'(stw_expected), 32'd0);
        chk("rst_strobes", 32'({stw_test_load_en, stw_start}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_case(cases[i]);

        // Async reset while idle clears held verdict/fault map.
        #1 rst = 1'b0;
        #1;
        chk("idle_rst_fmap", 32'(fault_map), 32'd0);
        chk("idle_rst_tout", 32'(bist_timeout), 32'd0);
        step();
        rst = 1'b1;
        step();

        // Reset during the WAIT of vector 2.
        auto_c = 1; inject = 0; stuck = 0; p1 = 0; p2 = 0;
        bist_start = 1'b1;
        step();
        bist_start = 1'b0;
        cyc = 1;
        while (cyc < 13) begin step(); cyc++; end
        chk("mid_op1_pre", 32'(stw_mult_op1), 32'h5555);
        chk("mid_busy_pre", 32'(bist_busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(bist_busy), 32'd0);
        chk("mid_rst_fmap", 32'(fault_map), 32'd0);
        chk("mid_rst_strobes",
            32'({stw_test_load_en, stw_start, bist_done}), 32'd0);
        chk("mid_rst_op1", 32'(stw_mult_op1), 32'd0);
        chk("mid_rst_exp", 32'(stw_expected), 32'd0);
        step();
        step();
        rst = 1'b1;
        repeat (3) step();
        chk("post_rst_idle", 32'({bist_busy, stw_test_load_en, stw_start}), 32'd0);
        run_case(cases[0]);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule

// File: doc/stw_bist_controller.md
# stw_bist_controller

Built-in self-test sequencer for the systolic array's STW (self-test word) port. It applies a fixed table of multiply-add test vectors to all PEs in parallel: for each vector it drives the operands and expected result, pulses load and start, then waits for the array's aggregate completion. It accumulates the per-PE result matrix into a sticky fault map for downstream repair logic, and reports pass, fail or timeout to the host.

## Interface
Parameters
- ROWS, 4, array rows
- COLS, 4, array columns
- WORD_SIZE, 16, operand width; minimum 8
- NUM_VECTORS, 4, vectors applied per run; range 1..4
- TIMEOUT, 64, maximum WAIT cycles per vector

Ports
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-low reset
- bist_start  in  1  single-cycle request; honoured only in IDLE
- bist_busy  out  1  high in every state except IDLE
- bist_done  out  1  one-cycle pulse when a run ends
- bist_pass  out  1  run verdict; held until the next accepted start
- bist_timeout  out  1  the run aborted on timeout; held until the next accepted start
- fault_map  out  ROWS*COLS  sticky per-PE fail map; bit index r*COLS+c
- stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected  out  WORD_SIZE each  current vector
- stw_test_load_en  out  1  operand load strobe to the array
- stw_start  out  1  test start strobe to the array
- stw_complete_in  in  1  AND of all PE completion flags
- stw_result_mat_in  in  ROWS*COLS  per-PE result; 1 = mismatch

## Operation
- Vector table, indexed by vec_idx. W = WORD_SIZE.
  - v0: op1=3, op2=5, add=7
  - v1: op1=all-ones, op2=1, add=1
  - v2: op1=0101…01 pattern, op2=2, add=0
  - v3: op1=0, op2=0, add=0
- stw_expected = (op1*op2 + add) mod 2^W, computed in the controller and registered with the operands.
- Resulting expected values: v0 = 22, v1 = 0 (wrap), v2 = 1010…10, v3 = 0.
- FSM states: IDLE, LOAD, START, WAIT, CAPTURE, DONE.
- IDLE → LOAD on bist_start. On this transition:
  - fault_map, bist_pass, bist_timeout and vec_idx clear.
  - The vector 0 operands are registered.
- LOAD: stw_test_load_en=1 for exactly one cycle, then go to START.
- START: stw_start=1 for exactly one cycle, then go to WAIT. The wait counter clears.
- WAIT:
  - The first WAIT cycle is a guard cycle: stw_complete_in is ignored.
  - From the second cycle, stw_complete_in=1 → CAPTURE.
  - The counter increments every WAIT cycle. If it reaches TIMEOUT before complete is seen, go to DONE with bist_timeout=1 and fault_map set to all ones.
- CAPTURE: fault_map |= stw_result_mat_in.
  - If vec_idx == NUM_VECTORS-1, go to DONE.
  - Otherwise increment vec_idx, register the next vector's operands, and go to LOAD.
- DONE: bist_done=1 for one cycle. bist_pass is registered as ~|fault_map & ~bist_timeout. Then go to IDLE.
- Operand outputs hold the current vector from LOAD through CAPTURE. They keep the last vector after DONE.
- bist_start is ignored in every state other than IDLE; there is no queueing.
- Reset values (asynchronous, on rst=0):
  - FSM returns to IDLE; vec_idx and the counter clear.
  - All outputs are 0, including fault_map, bist_pass, the operands and the strobes.

## Timing
- All outputs are registered or decoded from registered state; there is no combinational path from input to output.
- bist_start is sampled at edge 0. LOAD is visible in cycle 1 and START in cycle 2. WAIT begins in cycle 3.
- Earliest complete acceptance is cycle 4, giving CAPTURE in cycle 5.
- Minimum per-vector cost is 5 cycles. A full 4-vector run with immediate completion shows bist_done in cycle 21.
- The timeout path gives bist_done TIMEOUT+1 cycles after WAIT entry.
- stw_result_mat_in is sampled only in the CAPTURE cycle, one cycle after complete is seen. The array must hold the result at least that long.
- If complete stays high across vectors, it is still ignored in each guard cycle.
- Reset asserted mid-run aborts immediately. After release, the controller sits in IDLE with cleared outputs and waits for a new bist_start.

## Test plan
- Fault-free array:
  - Stimulus: model asserts complete 2 cycles after stw_start, result_mat=0.
  - Required: bist_done at cycle 21, bist_pass=1, fault_map=0. Operand/expected sequence (3,5,7,22), (FFFF,1,1,0), (5555,2,0,AAAA), (0,0,0,0) for W=16.
- Single-PE fault:
  - Stimulus: result_mat bit 5 set only during v2.
  - Required: fault_map=16'h0020, bist_pass=0, bist_timeout=0.
- Timeout:
  - Stimulus: TIMEOUT=8, complete never asserted.
  - Required: bist_done 9 cycles after WAIT entry, bist_timeout=1, fault_map=all ones, bist_pass=0, no CAPTURE state entered.
- Start ignored while busy:
  - Stimulus: bist_start pulsed during WAIT of v1.
  - Required: run completes normally; exactly one bist_done; next IDLE start required for a second run.
- Reset mid-run:
  - Stimulus: rst=0 during WAIT of v2.
  - Required: next edge shows IDLE, busy=0, fault_map=0, all strobes 0. A new run then passes.
- Complete stuck high:
  - Stimulus: complete held at 1 throughout.
  - Required: each vector still takes 5 cycles. stw_test_load_en and stw_start each pulse exactly once per vector.
